// File: rtl/branch_seq_pkg.sv
// rtl/branch_seq_pkg.sv - shared types and constants for the branch sequencer
package branch_seq_pkg;

    localparam int FLUSH_CNT_W = 4;

    typedef enum logic [2:0] {
        COND_NEVER  = 3'b000,
        COND_LT     = 3'b001,
        COND_EQ     = 3'b010,
        COND_LE     = 3'b011,
        COND_GT     = 3'b100,
        COND_NE     = 3'b101,
        COND_GE     = 3'b110,
        COND_ALWAYS = 3'b111
    } cond_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational 8-way compare-against-zero condition evaluator
module branch_cond_eval
    import branch_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [2:0]   cond,
    input  logic         unsigned_mode,
    input  logic [W-1:0] val,
    output logic         cond_true
);

    logic w_neg;
    logic w_zero;
    logic w_pos;

    // Unsigned operands can never be negative, so any nonzero value is positive.
    assign w_zero = ~|val;
    assign w_neg  = unsigned_mode ? 1'b0 : val[W-1];
    assign w_pos  = ~w_neg & ~w_zero;

    always_comb begin
        cond_true = 1'b0;
        case (cond_t'(cond))
            COND_NEVER:  cond_true = 1'b0;
            COND_LT:     cond_true = w_neg;
            COND_EQ:     cond_true = w_zero;
            COND_LE:     cond_true = w_neg | w_zero;
            COND_GT:     cond_true = w_pos;
            COND_NE:     cond_true = ~w_zero;
            COND_GE:     cond_true = ~w_neg;
            COND_ALWAYS: cond_true = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - PC owner with branch resolution, multi-cycle flush and halt/resume
// Optional taken-branch statistics counter enabled by BRANCH_SEQUENCER_STATS_EN.
module branch_sequencer
    import branch_seq_pkg::*;
#(
    parameter int             W            = 16,
    parameter logic [W-1:0]   RESET_PC     = '0,
    parameter int             PC_STEP      = 1,
    parameter int             FLUSH_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_in,
    input  logic         stall,
    input  logic         is_branch,
    input  logic [2:0]   cond,
    input  logic         unsigned_mode,
    input  logic [W-1:0] val,
    input  logic [W-1:0] target,
    input  logic         halt_req,
    input  logic         resume,
    output logic [W-1:0] pc,
    output logic         taken,
    output logic         flush,
    output logic         ready,
    output logic [W-1:0] taken_count
);

    localparam logic [W-1:0]           W_STEP   = W'(PC_STEP);
    localparam logic [FLUSH_CNT_W-1:0] CNT_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    state_t                 r_state;
    logic [W-1:0]           r_pc;
    logic                   r_taken;
    logic                   r_flush;
    logic [FLUSH_CNT_W-1:0] r_cnt;

    logic w_cond_true;
    logic w_accept;
    logic w_take;

    branch_cond_eval #(.W(W)) u_cond_eval (
        .cond          (cond),
        .unsigned_mode (unsigned_mode),
        .val           (val),
        .cond_true     (w_cond_true)
    );

    assign w_accept = (r_state == RUN) & valid_in & ~stall;
    assign w_take   = w_accept & is_branch & w_cond_true;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
            r_taken <= 1'b0;
            r_flush <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_taken <= 1'b0;
            case (r_state)
                RUN: begin
                    // A taken branch outranks a same-cycle halt; halt is re-sampled at flush exit.
                    if (w_take) begin
                        r_pc    <= target;
                        r_taken <= 1'b1;
                        r_flush <= 1'b1;
                        r_cnt   <= CNT_INIT;
                        r_state <= FLUSH;
                    end else begin
                        if (w_accept)
                            r_pc <= r_pc + W_STEP;
                        if (halt_req && !stall)
                            r_state <= HALT;
                    end
                end
                FLUSH: begin
                    if (r_cnt == '0) begin
                        r_flush <= 1'b0;
                        r_state <= halt_req ? HALT : RUN;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                HALT: begin
                    if (resume)
                        r_state <= RUN;
                end
                default: begin
                    r_state <= RUN;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    assign pc    = r_pc;
    assign taken = r_taken;
    assign flush = r_flush;
    assign ready = (r_state == RUN);

`ifdef BRANCH_SEQUENCER_STATS_EN
    logic [W-1:0] r_taken_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_taken_count <= '0;
        else if (w_take && !(&r_taken_count))
            r_taken_count <= r_taken_count + W'(1);
    end

    assign taken_count = r_taken_count;
`else
    assign taken_count = '0;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - directed self-checking bench for branch_sequencer (W=16, FLUSH_CYCLES=2)
module tb_branch_sequencer;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        stall;
    logic        is_branch;
    logic [2:0]  cond;
    logic        unsigned_mode;
    logic [15:0] val;
    logic [15:0] target;
    logic        halt_req;
    logic        resume;
    logic [15:0] pc;
    logic        taken;
    logic        flush;
    logic        ready;
    logic [15:0] taken_count;

    int checks;
    int errors;

    branch_sequencer #(
        .W            (16),
        .RESET_PC     (16'h0000),
        .PC_STEP      (1),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .stall         (stall),
        .is_branch     (is_branch),
        .cond          (cond),
        .unsigned_mode (unsigned_mode),
        .val           (val),
        .target        (target),
        .halt_req      (halt_req),
        .resume        (resume),
        .pc            (pc),
        .taken         (taken),
        .flush         (flush),
        .ready         (ready),
        .taken_count   (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [15:0] e_pc, input logic e_taken,
                             input logic e_flush, input logic e_ready);
        check({tag, ".pc"},    {16'h0, pc},      {16'h0, e_pc});
        check({tag, ".taken"}, {31'h0, taken},   {31'h0, e_taken});
        check({tag, ".flush"}, {31'h0, flush},   {31'h0, e_flush});
        check({tag, ".ready"}, {31'h0, ready},   {31'h0, e_ready});
    endtask

    task automatic drive(input logic v, input logic br, input logic [2:0] c, input logic um,
                         input logic [15:0] vv, input logic [15:0] tg);
        valid_in      = v;
        is_branch     = br;
        cond          = c;
        unsigned_mode = um;
        val           = vv;
        target        = tg;
    endtask

    logic [15:0] exp_cnt;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        stall = 1'b0;
        halt_req = 1'b0;
        resume = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 1'b0, 16'h0000, 16'h0000);
        step();
        step();
        check_out("reset", 16'h0000, 1'b0, 1'b0, 1'b1);
        check("reset.taken_count", {16'h0, taken_count}, 32'h0);
        rst = 1'b0;

        // Three sequential non-branch accepts
        drive(1'b1, 1'b0, 3'b000, 1'b0, 16'h0000, 16'h0000);
        step(); check_out("seq1", 16'h0001, 1'b0, 1'b0, 1'b1);
        step(); check_out("seq2", 16'h0002, 1'b0, 1'b0, 1'b1);
        step(); check_out("seq3", 16'h0003, 1'b0, 1'b0, 1'b1);

        // Signed lt on 0x8000 is taken; decode keeps pushing during flush and is ignored
        drive(1'b1, 1'b1, 3'b001, 1'b0, 16'h8000, 16'h0040);
        step(); check_out("lt_signed.f0", 16'h0040, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 3'b111, 1'b0, 16'h0000, 16'h1234);
        step(); check_out("lt_signed.f1", 16'h0040, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 3'b000, 1'b0, 16'h0000, 16'h0000);
        step(); check_out("lt_signed.exit", 16'h0040, 1'b0, 1'b0, 1'b1);

        // Same operand unsigned: lt not taken, gt taken
        drive(1'b1, 1'b1, 3'b001, 1'b1, 16'h8000, 16'h0040);
        step(); check_out("lt_unsigned", 16'h0041, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 3'b100, 1'b1, 16'h8000, 16'h0100);
        step(); check_out("gt_unsigned", 16'h0100, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 3'b000, 1'b0, 16'h0000, 16'h0000);
        step(); step(); check_out("gt_unsigned.exit", 16'h0100, 1'b0, 1'b0, 1'b1);

        // Signed ge on a negative value is not taken
        drive(1'b1, 1'b1, 3'b110, 1'b0, 16'hFFFE, 16'h0777);
        step(); check_out("ge_signed_neg", 16'h0101, 1'b0, 1'b0, 1'b1);

        // Jump to 0xFFFF then wrap on a non-branch accept
        drive(1'b1, 1'b1, 3'b111, 1'b0, 16'h0000, 16'hFFFF);
        step(); check_out("jmp_ffff", 16'hFFFF, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 3'b000, 1'b0, 16'h0000, 16'h0000);
        step(); step();
        drive(1'b1, 1'b0, 3'b000, 1'b0, 16'h0000, 16'h0000);
        step(); check_out("wrap", 16'h0000, 1'b0, 1'b0, 1'b1);

        // Stall with valid and halt_req: everything held, halt ignored
        stall = 1'b1;
        halt_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check_out("stall", 16'h0000, 1'b0, 1'b0, 1'b1);
        end
        stall = 1'b0;

        // Taken branch with halt_req: flush first, then halt at flush exit
        drive(1'b1, 1'b1, 3'b111, 1'b0, 16'h0000, 16'h0200);
        step(); check_out("halt_br.f0", 16'h0200, 1'b1, 1'b1, 1'b0);
        step(); check_out("halt_br.f1", 16'h0200, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 3'b000, 1'b0, 16'h0000, 16'h0000);
        step(); check_out("halt_br.halt", 16'h0200, 1'b0, 1'b0, 1'b0);
        step(); check_out("halt_br.hold", 16'h0200, 1'b0, 1'b0, 1'b0);
        halt_req = 1'b0;
        resume = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 1'b0, 16'h0000, 16'h0000);
        step(); check_out("resume", 16'h0200, 1'b0, 1'b0, 1'b1);
        resume = 1'b0;

        // Halt with a non-branch accept: advance completes, then HALT
        halt_req = 1'b1;
        drive(1'b1, 1'b0, 3'b000, 1'b0, 16'h0000, 16'h0000);
        step(); check_out("halt_seq", 16'h0201, 1'b0, 1'b0, 1'b0);
        halt_req = 1'b0;
        resume = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 1'b0, 16'h0000, 16'h0000);
        step(); check_out("resume2", 16'h0201, 1'b0, 1'b0, 1'b1);
        resume = 1'b0;

        // Fifth taken branch (eq on zero), then async reset mid-flush
        drive(1'b1, 1'b1, 3'b010, 1'b0, 16'h0000, 16'h0300);
        step(); check_out("eq_zero", 16'h0300, 1'b1, 1'b1, 1'b0);
`ifdef BRANCH_SEQUENCER_STATS_EN
        exp_cnt = 16'd5;
`else
        exp_cnt = 16'd0;
`endif
        check("taken_count", {16'h0, taken_count}, {16'h0, exp_cnt});
        drive(1'b0, 1'b0, 3'b000, 1'b0, 16'h0000, 16'h0000);
        #2 rst = 1'b1;
        #1;
        check_out("async_rst", 16'h0000, 1'b0, 1'b0, 1'b1);
        check("async_rst.taken_count", {16'h0, taken_count}, 32'h0);
        step();
        rst = 1'b0;
        drive(1'b1, 1'b0, 3'b000, 1'b0, 16'h0000, 16'h0000);
        step(); check_out("post_rst", 16'h0001, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
